// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - switch-pattern frame sequencer with debounced write request
// Serializes {sw4..sw1} as START, 4 data bits (LSB first), STOP, then optional idle gap.
module frame_sequencer #(
  parameter int CLK_DIV  = 100,
  parameter int DEBOUNCE = 16,
  parameter int GAP_BITS = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       write,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sw4,
  output logic       out,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] code
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t          state, state_n;
  logic [1:0]      write_sync;
  logic [3:0]      sw_sync0, sw_sync1;
  logic            write_db;
  logic [DW-1:0]   db_cnt;
  logic [PW-1:0]   presc, presc_n;
  logic [1:0]      bit_idx, bit_idx_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [3:0]      code_n;
  logic            out_n, busy_n, bit_end;

  // The toggle lands on the sample after DEBOUNCE disagreeing ones, so write_db
  // follows a clean edge on write by 2+DEBOUNCE edges.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      write_sync <= '0;
      sw_sync0   <= '0;
      sw_sync1   <= '0;
      write_db   <= 1'b0;
      db_cnt     <= '0;
    end else begin
      write_sync <= {write_sync[0], write};
      sw_sync0   <= {sw4, sw3, sw2, sw1};
      sw_sync1   <= sw_sync0;
      if (write_sync[1] == write_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        write_db <= ~write_db;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign bit_end    = (presc == PRESC_LAST);
  assign frame_done = (state == STOP) && bit_end;

  always_comb begin
    state_n   = state;
    presc_n   = bit_end ? '0 : presc + PW'(1);
    bit_idx_n = bit_idx;
    gap_n     = gap_cnt;
    code_n    = code;
    case (state)
      IDLE:  if (write_db) state_n = START;
      START: if (bit_end) state_n = DATA;
      DATA:  if (bit_end) begin
               if (bit_idx == 2'd3) state_n = STOP;
               else bit_idx_n = bit_idx + 2'd1;
             end
      STOP:  if (bit_end) begin
               if (!write_db)         state_n = IDLE;
               else if (GAP_BITS > 0) state_n = GAP;
               else                   state_n = START;
             end
      GAP:   if (!write_db) begin
               state_n = IDLE;
             end else if (bit_end) begin
               if (gap_cnt == GAP_LAST) state_n = START;
               else gap_n = gap_cnt + GW'(1);
             end
      default: state_n = IDLE;
    endcase
    if (state_n != state) begin
      presc_n   = '0;
      bit_idx_n = '0;
      gap_n     = '0;
      if (state_n == START) code_n = sw_sync1;
    end
    case (state_n)
      START:   out_n = 1'b1;
      DATA:    out_n = code_n[bit_idx_n];
      default: out_n = 1'b0;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      presc   <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
      code    <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      bit_idx <= bit_idx_n;
      gap_cnt <= gap_n;
      code    <= code_n;
      out     <= out_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer
module tb_frame_sequencer;

  logic       sysclk = 1'b0;
  logic       rst_n, write, sw1, sw2, sw3, sw4;
  logic       out, busy, frame_done;
  logic [3:0] code;
  logic       out0, busy0, frame_done0;
  logic [3:0] code0;
  int         checks = 0;
  int         errors = 0;
  int         bcnt, fcnt;

  always #5 sysclk = ~sysclk;

  frame_sequencer #(.CLK_DIV(4), .DEBOUNCE(3), .GAP_BITS(2)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .write(write),
    .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4),
    .out(out), .busy(busy), .frame_done(frame_done), .code(code)
  );

  frame_sequencer #(.CLK_DIV(4), .DEBOUNCE(3), .GAP_BITS(0)) dut0 (
    .sysclk(sysclk), .rst_n(rst_n), .write(write),
    .sw1(sw1), .sw2(sw2), .sw3(sw3), .sw4(sw4),
    .out(out0), .busy(busy0), .frame_done(frame_done0), .code(code0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    {sw4, sw3, sw2, sw1} = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Expected out for a frame with CLK_DIV=4 whose START begins at cycle s.
  function automatic logic fbit(input int c, input int s, input logic [3:0] cd);
    int b;
    if (c < s || c >= s + 24) return 1'b0;
    b = (c - s) / 4;
    if (b == 0) return 1'b1;
    if (b <= 4) return cd[b-1];
    return 1'b0;
  endfunction

  initial begin
    rst_n = 1'b0;
    write = 1'b0;
    set_sw(4'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      write = 1'($urandom_range(0, 1));
      set_sw(4'($urandom));
      #1;
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_fd", frame_done, 0);
      check("rst_code", code, 0);
    end
    @(negedge sysclk);
    write = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      check("post_rst_out", out, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_fd", frame_done, 0);
      check("post_rst_code", code, 0);
    end

    // single frame, write held for 10 cycles
    set_sw(4'b0101);
    idle(4);
    write = 1'b1;
    bcnt = 0;
    fcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      check($sformatf("single_out_c%0d", c), out, fbit(c, 6, 4'h5));
      check($sformatf("single_busy_c%0d", c), busy, (c >= 6 && c <= 29));
      check($sformatf("single_fd_c%0d", c), frame_done, (c == 29));
      bcnt += int'(busy);
      fcnt += int'(frame_done);
      if (c == 9) write = 1'b0;
    end
    check("single_busy_cycles", bcnt, 24);
    check("single_fd_count", fcnt, 1);
    check("single_code", code, 4'h5);

    // glitch rejection
    idle(10);
    write = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      if (c == 1) write = 1'b0;
      check($sformatf("glitch_busy_c%0d", c), busy, 0);
      check($sformatf("glitch_out_c%0d", c), out, 0);
    end

    // repeated frames, switches change during frame 1 DATA
    idle(10);
    set_sw(4'b0011);
    idle(4);
    write = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      check($sformatf("rep_out_c%0d", c), out, fbit(c, 6, 4'h3) | fbit(c, 38, 4'h8));
      check($sformatf("rep_busy_c%0d", c), busy, (c >= 6 && c <= 68));
      check($sformatf("rep_fd_c%0d", c), frame_done, (c == 29 || c == 61));
      if (c == 20) check("rep_code1", code, 4'h3);
      if (c == 40) check("rep_code2", code, 4'h8);
      if (c == 15) set_sw(4'b1000);
      if (c == 62) write = 1'b0;
    end

    // GAP_BITS=0: back-to-back frames
    idle(10);
    set_sw(4'b0110);
    idle(4);
    write = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      check($sformatf("nogap_out_c%0d", c), out0, fbit(c, 6, 4'h6) | fbit(c, 30, 4'h6));
      check($sformatf("nogap_busy_c%0d", c), busy0, (c >= 6 && c <= 53));
      check($sformatf("nogap_fd_c%0d", c), frame_done0, (c == 29 || c == 53));
      if (c == 40) write = 1'b0;
    end

    // reset during DATA bit 2, then restart with write still high
    idle(10);
    set_sw(4'b0111);
    idle(4);
    write = 1'b1;
    repeat (20) begin
      @(posedge sysclk);
      @(negedge sysclk);
    end
    check("mid_pre_out", out, 1);
    check("mid_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_code", code, 0);
    check("mid_rst_fd", frame_done, 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      check($sformatf("restart_out_c%0d", c), out, fbit(c, 6, 4'h7));
      check($sformatf("restart_busy_c%0d", c), busy, (c >= 6));
      check($sformatf("restart_fd_c%0d", c), frame_done, (c == 29));
    end
    write = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Sequencer for the switch-driven serial output path. Synchronizes and debounces the `write` strobe, snapshots the four switches `sw1`..`sw4` as a 4-bit code, and serializes that code as a framed bit stream on `out` at a programmable bit rate. Frames repeat for as long as `write` is held. It sits between the board inputs and the output pin, replacing free-running pattern logic with a deterministic, testable schedule.

## Interface
- `CLK_DIV`, default 100: `sysclk` cycles per serial bit; must be ≥2.
- `DEBOUNCE`, default 16: consecutive stable synchronized samples required to accept a change on `write`; must be ≥1.
- `GAP_BITS`, default 2: idle bit-times inserted between repeated frames; 0 allowed.
- `sysclk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `write` in 1: asynchronous request; high means transmit frames.
- `sw1`..`sw4` in 1 each: asynchronous pattern bits; `sw1` is the LSB.
- `out` in→out 1: serial output, registered.
- `busy` out 1: high in any state other than IDLE, registered.
- `frame_done` out 1: one-cycle pulse on the last cycle of each STOP bit.
- `code` out 4: last snapshotted pattern `{sw4,sw3,sw2,sw1}`.

## Operation
- Input conditioning:
  - `write` and `sw1`..`sw4` each pass through a 2-flop synchronizer.
  - `write_db` toggles only after the synchronized `write` has differed from `write_db` for `DEBOUNCE` consecutive cycles; the counter clears on any agreeing sample.
  - Switches are not debounced.
- States: IDLE, START, DATA, STOP, GAP. A prescaler counts 0..`CLK_DIV`-1 within each bit. `bit_idx` (0..3) is used in DATA, and a gap counter in GAP.
- Transitions:
  - IDLE→START when `write_db`=1.
  - START→DATA after 1 bit-time.
  - DATA→STOP after 4 bit-times.
  - STOP→GAP, if `write_db`=1 and `GAP_BITS`>0.
  - STOP→START, if `write_db`=1 and `GAP_BITS`=0.
  - STOP→IDLE, if `write_db`=0.
  - GAP→START after `GAP_BITS` bit-times if `write_db`=1. Otherwise GAP→IDLE immediately, on the cycle `write_db` is seen 0.
- `out` per state: IDLE 0, START 1, DATA `code[bit_idx]` (LSB first), STOP 0, GAP 0.
- Snapshot: `code` loads from the synchronized switches on every transition into START. Switch changes at any other time do not affect the frame in flight.
- `write_db` falling during START, DATA or STOP does not truncate the frame; the frame completes, then the block goes to IDLE.
- Prescaler and `bit_idx` clear on every state transition.

## Timing
- Reset (async assert, sync release): `out`=0, `busy`=0, `frame_done`=0, `code`=0. The state is IDLE, and all counters, synchronizers and `write_db` are 0. Assertion mid-frame aborts immediately, with no completion of the frame.
- Latency: `write` stable high, first sampled at edge 0.
  - `write_db`=1 after edge 2+`DEBOUNCE`.
  - The state enters START, and `out`=1 and `busy`=1 become visible, after edge 3+`DEBOUNCE`.
- Each bit lasts exactly `CLK_DIV` cycles.
- A frame is 6·`CLK_DIV` cycles. The repeat period is (6+`GAP_BITS`)·`CLK_DIV` cycles.
- `frame_done` is high for exactly 1 cycle per frame, coincident with prescaler=`CLK_DIV`-1 in STOP.
- `busy` falls on the same edge that enters IDLE.
- Simultaneous events:
  - When `write_db` falls on the last STOP cycle, the decision uses the registered `write_db` value at that edge.
  - `frame_done` still pulses.
- A `write` pulse shorter than `DEBOUNCE` cycles after synchronization produces no frame and no `busy`.

## Test plan
- Reset check: hold `rst_n`=0 with random inputs → `out`=0, `busy`=0, `frame_done`=0, `code`=0 throughout. Release with `write`=0 → outputs stay 0 for 100 cycles.
- Single frame: `CLK_DIV`=4, `DEBOUNCE`=3, `GAP_BITS`=2, switches=0101. Raise `write`, then drop it after 10 cycles.
  - `out` goes 1 at edge 6 and follows 1,1,0,1,0,0 per 4-cycle bit.
  - `frame_done` pulses once, at cycle 29.
  - `busy` is high for 24 cycles; `code`=0x5.
- Glitch rejection: same params, 2-cycle `write` pulse → `busy` never asserts and `out` stays 0.
- Repeat with switch change: `write` held. Switches 0011 for frame 1, then changed to 1000 during frame 1's DATA.
  - Frame 1 carries 0011.
  - Then 8 cycles of gap (0).
  - Frame 2 carries 1000 (`code`=0x8).
  - `frame_done` pulses are 32 cycles apart.
- `GAP_BITS`=0 with `write` held → STOP is followed directly by START. `out` shows 0 then 1 at the frame boundary, with back-to-back 24-cycle frames.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 2 → the same cycle gives `out`=0 and `busy`=0. After release with `write` still high, a fresh frame starts `DEBOUNCE`+3 edges later.
